ccff_chain_loader: RTL

// - Upstream feeder of a tile's configuration-chain: accepts bitstream words over valid/ready,

---
 rtl/ccff_chain_loader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// Configuration-chain feeder: takes bitstream words over valid/ready, shifts CHAIN_LEN bits
// MSB-first onto ccff_head with a registered clock enable. Define CCFF_READBACK_EN for tail readback.
module ccff_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 48,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    bits_left_q;
  logic [CNT_W-1:0]    word_bits_q;
  logic [WORD_W-1:0]   sreg_q;
  logic [WORD_W-1:0]   sreg_shl;
  logic                head_q;
  logic                clk_en_q;
  logic                word_last;
  logic                load_last;

  assign sreg_shl    = sreg_q << 1;
  assign word_last   = (word_bits_q == ONE_C);
  assign load_last   = word_last && (bits_left_q == ONE_C);
  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        busy      = 1'b1;
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (word_last) state_d = load_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q     <= S_IDLE;
      bits_left_q <= '0;
      word_bits_q <= '0;
      sreg_q      <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (start) bits_left_q <= LEN_C;
        end
        S_FETCH: begin
          if (cfg_valid) begin
            sreg_q      <= cfg_data;
            word_bits_q <= (bits_left_q < WORD_C) ? bits_left_q : WORD_C;
            head_q      <= cfg_data[WORD_W-1];
            clk_en_q    <= 1'b1;
          end
        end
        S_SHIFT: begin
          sreg_q      <= sreg_shl;
          word_bits_q <= word_bits_q - ONE_C;
          bits_left_q <= bits_left_q - ONE_C;
          // Head is driven one cycle ahead so it lines up with the registered enable.
          if (word_last) clk_en_q <= 1'b0;
          else           head_q   <= sreg_shl[WORD_W-1];
        end
        default: ;
      endcase
    end
  end

`ifdef CCFF_READBACK_EN
  logic [WORD_W-1:0] rb_sreg_q;
  logic [WORD_W-1:0] rb_next;
  logic [CNT_W-1:0]  rb_cnt_q;

  assign rb_next = (rb_sreg_q << 1) | WORD_W'(ccff_tail);

  // The tail bit seen on an enabled edge is the chain's old content leaving the far end.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      rb_sreg_q <= '0;
      rb_cnt_q  <= '0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (clk_en_q) begin
        if (rb_cnt_q == CNT_W'(WORD_W - 1) || load_last) begin
          rb_valid  <= 1'b1;
          rb_data   <= rb_next << (CNT_W'(WORD_W - 1) - rb_cnt_q);
          rb_sreg_q <= '0;
          rb_cnt_q  <= '0;
        end else begin
          rb_sreg_q <= rb_next;
          rb_cnt_q  <= rb_cnt_q + ONE_C;
        end
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule
